// File: rtl/frame_bus_arbiter.sv
// Round-robin arbiter for a shared frame-based bus: grants one master at a time,
// holds ownership across frame, revokes unused grants and inserts a turnaround cycle.
module frame_bus_arbiter #(
  parameter int N           = 4,
  parameter int GNT_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 frame,
  output logic [N-1:0]         grant,
  output logic                 aquired,
  output logic [$clog2(N)-1:0] owner,
  output logic                 timeout
);

  localparam int W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t       state;
  logic [W-1:0] ptr;
  logic [7:0]   wcnt;

  logic [W-1:0] pick;
  logic         found;
  logic [W:0]   idx;
  logic [W-1:0] ptr_next;

  // First asserted request at or after ptr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (W+1)'(i);
      if (idx >= (W+1)'(N))
        idx = idx - (W+1)'(N);
      if (!found && req[idx[W-1:0]]) begin
        found = 1'b1;
        pick  = idx[W-1:0];
      end
    end
  end

  assign ptr_next = (owner == W'(N-1)) ? '0 : owner + W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      wcnt    <= '0;
      grant   <= '0;
      aquired <= 1'b0;
      owner   <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          wcnt <= '0;
          if (found) begin
            state <= GRANT;
            grant <= N'(1) << pick;
            owner <= pick;
          end
        end
        GRANT: begin
          if (frame) begin
            state   <= BUSY;
            aquired <= 1'b1;
          end else if (!req[owner]) begin
            state <= TURN;
            grant <= '0;
            owner <= '0;
            ptr   <= ptr_next;
          end else if (wcnt == 8'(GNT_TIMEOUT - 1)) begin
            state   <= TURN;
            grant   <= '0;
            owner   <= '0;
            ptr     <= ptr_next;
            timeout <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        BUSY: begin
          if (!frame) begin
            state   <= TURN;
            grant   <= '0;
            aquired <= 1'b0;
            owner   <= '0;
            ptr     <= ptr_next;
          end
        end
        TURN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_bus_arbiter.sv
// Bench for frame_bus_arbiter: directed episodes plus random traffic, checked
// cycle by cycle against an ownership-level model through an expectation queue.
module tb_frame_bus_arbiter;

  localparam int N = 4;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         frame;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         aquired;
  logic [1:0]   owner;
  logic         timeout;

  always #5 clk = ~clk;

  frame_bus_arbiter #(.N(N), .GNT_TIMEOUT(T)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .frame   (frame),
    .grant   (grant),
    .aquired (aquired),
    .owner   (owner),
    .timeout (timeout)
  );

  typedef struct packed {
    logic [N-1:0] grant;
    logic         aquired;
    logic [1:0]   owner;
    logic         timeout;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   run         = 1'b1;

  // Model: who owns the bus, for how long, whether the transfer has started,
  // how many idle edges remain before the next arbitration, and next priority.
  int m_owner = -1;
  int m_age   = 0;
  bit m_busy  = 1'b0;
  int m_gap   = 0;
  int m_next  = 0;
  bit m_to    = 1'b0;
  int pc      = 0;

  task automatic release_bus();
    m_next  = (m_owner + 1) % N;
    m_owner = -1;
    m_busy  = 1'b0;
    m_gap   = 1;
  endtask

  task automatic model_step();
    exp_t e;
    int   c;
    m_to = 1'b0;
    if (reset) begin
      m_owner = -1; m_busy = 1'b0; m_gap = 0; m_next = 0;
    end else if (m_owner >= 0) begin
      if (m_busy) begin
        if (!frame) release_bus();
      end else if (frame) begin
        m_busy = 1'b1;
      end else if (!req[m_owner]) begin
        release_bus();
      end else if (m_age == T) begin
        release_bus();
        m_to = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int i = 0; i < N; i++) begin
        c = (m_next + i) % N;
        if (req[c] && m_owner < 0) begin
          m_owner = c;
          m_age   = 1;
        end
      end
    end
    e = '0;
    if (m_owner >= 0) begin
      e.grant[m_owner] = 1'b1;
      e.owner          = 2'(m_owner);
    end
    e.aquired = m_busy;
    e.timeout = m_to;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    if (run) model_step();
  end

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if ({grant, aquired, owner, timeout} !== mon_e) begin
        miscompares++;
        $display("FAIL outputs t=%0t: got grant=%b aquired=%b owner=%0d timeout=%b, required grant=%b aquired=%b owner=%0d timeout=%b",
                 $time, grant, aquired, owner, timeout,
                 mon_e.grant, mon_e.aquired, mon_e.owner, mon_e.timeout);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic [N-1:0] r, input logic f, input logic rs);
    req   = r;
    frame = f;
    reset = rs;
    @(posedge clk);
    #1;
  endtask

  // Granted master raises frame d cycles after seeing its grant, for l cycles.
  function automatic logic master_frame(int d, int l);
    if (m_owner < 0) begin
      pc = 0;
      return 1'b0;
    end
    pc++;
    return (pc - 1 >= d) && (pc - 1 < d + l);
  endfunction

  initial begin
    int           d, l;
    bit           planned;
    logic [N-1:0] r;
    logic         f, rs;

    req = '0; frame = 1'b0; reset = 1'b1;
    @(posedge clk); #1;

    // Reset with everyone requesting, then round robin with 3-cycle frames.
    drive(4'b1111, 1'b0, 1'b1);
    drive(4'b1111, 1'b0, 1'b1);
    repeat (34) drive(4'b1111, master_frame(0, 3), 1'b0);
    repeat (4) drive(4'b0000, 1'b0, 1'b0);

    // Unused grant times out, then is re-issued to the same lone requester.
    repeat (24) drive(4'b0100, 1'b0, 1'b0);
    repeat (4) drive(4'b0000, 1'b0, 1'b0);

    // Master 1 drops its request three cycles into the grant.
    for (int i = 0; i < 8 && m_owner != 1; i++) drive(4'b0010, 1'b0, 1'b0);
    repeat (2) drive(4'b0010, 1'b0, 1'b0);
    repeat (5) drive(4'b0000, 1'b0, 1'b0);

    // Master 3 keeps frame high after dropping req.
    for (int i = 0; i < 12 && !m_busy; i++) drive(4'b1000, master_frame(1, 7), 1'b0);
    repeat (10) drive(4'b0000, master_frame(1, 7), 1'b0);
    repeat (3) drive(4'b0000, 1'b0, 1'b0);

    // Reset while a transfer is in progress, then master 3 alone requests.
    for (int i = 0; i < 12 && !m_busy; i++) drive(4'b1000, master_frame(0, 20), 1'b0);
    drive(4'b1000, 1'b1, 1'b0);
    drive(4'b1000, 1'b1, 1'b1);
    repeat (6) drive(4'b1000, 1'b0, 1'b0);

    // Random traffic.
    planned = 1'b0; d = 0; l = 1; r = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_owner < 0) begin
        planned = 1'b0;
      end else if (!planned) begin
        planned = 1'b1;
        d = int'($urandom_range(0, 10));
        l = int'($urandom_range(1, 6));
      end
      if (planned) f = master_frame(d, l);
      else begin
        f = ($urandom_range(0, 7) == 0);
        pc = 0;
      end
      if ($urandom_range(0, 5) == 0) r = N'($urandom);
      rs = ($urandom_range(0, 199) == 0);
      drive(r, f, rs);
    end

    run = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
